data_req_gen: RTL and testbench
===============================

# data_req_gen

Parametrised input-feature-map read-address generator for the convolution datapath. It sits between the layer controller and the data block RAM. It walks a full convolution window schedule over configurable input width, height, channel count, kernel size, stride and symmetric zero padding, and issues one read slot per (output pixel, kernel tap, channel). Padded taps are flagged to the consumer instead of being read.

## Interface
Parameters:
- ADDR_WIDTH, 32, data RAM address width
- DIM_WIDTH, 8, width of input W/H
- CH_WIDTH, 8, width of channel count
- KSIZE_WIDTH, 3, width of kernel size (max 7)
- STRIDE_WIDTH, 4, width of stride
- PADDING_WIDTH, 4, width of padding

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_start  in  1  one-cycle pulse; latches config, starts a layer; ignored unless idle
- i_stall  in  1  consumer back-pressure; freezes the generator
- i_cfg_base_addr  in  ADDR_WIDTH  feature-map base address
- i_cfg_in_w / i_cfg_in_h  in  DIM_WIDTH  input width / height
- i_cfg_in_ch  in  CH_WIDTH  channel count C
- i_cfg_knl  in  KSIZE_WIDTH  kernel size K (square)
- i_cfg_stride  in  STRIDE_WIDTH  stride S
- i_cfg_pad  in  PADDING_WIDTH  padding P on every edge
- o_addr  out  ADDR_WIDTH  read address; valid when o_rden
- o_rden  out  1  read enable
- o_pad  out  1  slot is padding; consumer substitutes zero; no read
- o_busy  out  1  high from RUN through DONE
- o_done  out  1  one-cycle end-of-layer pulse
- o_err  out  1  one-cycle pulse with o_done on invalid config

## Operation
- Memory layout: HWC. The address of (iy, ix, c) is base + (iy*W + ix)*C + c.
- Loop order, outermost first: window row wy, window column wx, tap ky, tap kx, channel c.
- wy and wx are signed, DIM_WIDTH+2 bits. Both start at -P and step by S.
- A window is legal while wy+K <= H+P (respectively wx+K <= W+P). Output dims are therefore (H+2P-K)/S+1, floored.
- For each tap: iy = wy+ky, ix = wx+kx. The tap is padding if iy<0, ix<0, iy>=H or ix>=W. A padding slot asserts o_pad with o_rden=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE->RUN on i_start with valid config.
  - IDLE->DONE on i_start with invalid config: K=0, S=0, W=0, H=0, C=0, or K>H+2P, or K>W+2P. o_err is asserted in this case.
  - RUN->DRAIN once the last slot enters the pipeline.
  - DRAIN->DONE when the pipeline is empty.
  - DONE->IDLE after one cycle. o_done is asserted during DONE.
- Address pipeline, 2 stages:
  - S1 registers iy*W+ix and the pad flag.
  - S2 registers (S1)*C + c + base. Address arithmetic is in ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH.
- i_start while busy is ignored. Config inputs are sampled only at i_start.

## Timing
- Reset: state IDLE. All counters and pipeline registers are 0. o_addr=0. o_rden, o_pad, o_busy, o_done and o_err are all 0. rst asserted mid-RUN clears everything immediately; no o_done is produced.
- Latency: i_start in cycle 0, RUN in cycle 1, first o_rden/o_pad in cycle 3. In unstalled operation one slot is produced per cycle.
- o_done fires 1 cycle after the last slot. On invalid config, o_done and o_err fire in cycle 1.
- Stall: while i_stall is high, the counters and both pipeline stages hold. o_rden and o_pad are forced low combinationally. The held slot is issued in the first cycle that i_stall is low. No slot is dropped or duplicated.
- Exactly one of o_rden and o_pad is high per issued slot. Neither is ever high in IDLE or DONE.

## Structure
- Shared package:
  - FSM state localparams
  - config field widths
  - the signed window-coordinate width DIM_WIDTH+2
- Submodule data_req_addr_pipe: the two-stage address and pad pipeline with a common stall enable.
- Top level: FSM, nested loop counters, config latch.

## Test plan
- Basic: W=H=4, C=1, K=3, S=1, P=0, base=0 -> 36 reads. First window addresses are 0,1,2,4,5,6,8,9,10. The last address is 15. o_done follows 1 cycle after the last read. Zero o_pad.
- Padding: same config with P=1 -> 144 slots. The first window is pad, pad, pad, pad, 0, 1, pad, 4, 5.
- Channels: W=H=3, C=3, K=3, S=1, P=0, base=0x100 -> 27 reads at 0x100..0x11A, in order.
- Stride: W=H=5, K=3, S=2, P=0, C=1 -> 4 windows with origins (0,0), (0,2), (2,0), (2,2). Their first addresses are 0, 2, 10, 12.
- Stall: 30% random i_stall on the padding case -> the slot sequence is identical to the unstalled run. o_rden is never high with i_stall.
- Errors/reset: K=0 -> o_done and o_err in cycle 1, no reads. i_start while busy is ignored. rst mid-RUN returns all outputs to 0 immediately, and a subsequent start runs cleanly.

Source files
------------

// File: rtl/data_req_gen_pkg.sv
// Shared types and width helpers for the convolution feature-map read-address generator.
package data_req_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_ADDR_WIDTH    = 32;
    localparam int DEF_DIM_WIDTH     = 8;
    localparam int DEF_CH_WIDTH      = 8;
    localparam int DEF_KSIZE_WIDTH   = 3;
    localparam int DEF_STRIDE_WIDTH  = 4;
    localparam int DEF_PADDING_WIDTH = 4;

    // Window origins go negative by the padding and overshoot the far edge by a stride.
    localparam int COORD_MARGIN = 2;

    function automatic int coord_width(input int dim_width);
        return dim_width + COORD_MARGIN;
    endfunction

endpackage

// File: rtl/data_req_addr_pipe.sv
// Two-stage address pipeline: S1 holds the pixel index and pad flag, S2 the final HWC address.
module data_req_addr_pipe
    import data_req_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CH_WIDTH   = DEF_CH_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic                  in_pad,
    input  logic [ADDR_WIDTH-1:0] in_lin,
    input  logic [CH_WIDTH-1:0]   in_ch,
    input  logic [CH_WIDTH-1:0]   cfg_ch,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    output logic                  s1_valid,
    output logic                  out_valid,
    output logic                  out_pad,
    output logic [ADDR_WIDTH-1:0] out_addr
);

    logic                  s1_pad;
    logic [ADDR_WIDTH-1:0] s1_lin;
    logic [CH_WIDTH-1:0]   s1_ch;
    logic                  s2_valid;
    logic                  s2_pad;
    logic [ADDR_WIDTH-1:0] s2_addr;

    // Both stages share one enable so a stalled slot stays aligned with its pad flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_pad   <= 1'b0;
            s1_lin   <= '0;
            s1_ch    <= '0;
            s2_valid <= 1'b0;
            s2_pad   <= 1'b0;
            s2_addr  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_pad   <= in_pad;
            s1_lin   <= in_lin;
            s1_ch    <= in_ch;
            s2_valid <= s1_valid;
            s2_pad   <= s1_pad;
            s2_addr  <= s1_lin * ADDR_WIDTH'(cfg_ch) + ADDR_WIDTH'(s1_ch) + cfg_base;
        end
    end

    assign out_valid = s2_valid;
    assign out_pad   = s2_pad;
    assign out_addr  = s2_addr;

endmodule

// File: rtl/data_req_gen.sv
// Walks the convolution window schedule (wy, wx, ky, kx, c) and issues one read or pad slot per step.
module data_req_gen
    import data_req_gen_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DIM_WIDTH     = DEF_DIM_WIDTH,
    parameter int CH_WIDTH      = DEF_CH_WIDTH,
    parameter int KSIZE_WIDTH   = DEF_KSIZE_WIDTH,
    parameter int STRIDE_WIDTH  = DEF_STRIDE_WIDTH,
    parameter int PADDING_WIDTH = DEF_PADDING_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_stall,
    input  logic [ADDR_WIDTH-1:0]    i_cfg_base_addr,
    input  logic [DIM_WIDTH-1:0]     i_cfg_in_w,
    input  logic [DIM_WIDTH-1:0]     i_cfg_in_h,
    input  logic [CH_WIDTH-1:0]      i_cfg_in_ch,
    input  logic [KSIZE_WIDTH-1:0]   i_cfg_knl,
    input  logic [STRIDE_WIDTH-1:0]  i_cfg_stride,
    input  logic [PADDING_WIDTH-1:0] i_cfg_pad,
    output logic [ADDR_WIDTH-1:0]    o_addr,
    output logic                     o_rden,
    output logic                     o_pad,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    localparam int CW = coord_width(DIM_WIDTH);
    localparam int EW = CW + 2;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0]    cfg_base;
    logic [DIM_WIDTH-1:0]     cfg_w;
    logic [DIM_WIDTH-1:0]     cfg_h;
    logic [CH_WIDTH-1:0]      cfg_ch;
    logic [KSIZE_WIDTH-1:0]   cfg_knl;
    logic [STRIDE_WIDTH-1:0]  cfg_stride;
    logic [PADDING_WIDTH-1:0] cfg_pad;
    logic                     err_q;

    logic signed [CW-1:0]     wy, wx;
    logic [KSIZE_WIDTH-1:0]   ky, kx;
    logic [CH_WIDTH-1:0]      ch_cnt;

    logic                     start_ok;
    logic                     cfg_bad;
    logic [EW-1:0]            in_knl, in_w2p, in_h2p;
    logic signed [CW-1:0]     neg_pad_in, neg_pad_cfg;

    logic signed [EW-1:0]     wy_e, wx_e, ky_e, kx_e, iy_e, ix_e;
    logic signed [EW-1:0]     knl_e, stride_e, pad_e, w_e, h_e;
    logic                     wy_more, wx_more;
    logic                     c_last, kx_last, ky_last, tap_last, slot_last;
    logic                     tap_pad;
    logic [ADDR_WIDTH-1:0]    tap_lin;
    logic                     advance;

    logic                     s1_valid;
    logic                     out_valid;
    logic                     out_pad;
    logic [ADDR_WIDTH-1:0]    out_addr;

    assign start_ok = (state == ST_IDLE) && i_start;

    // A kernel larger than the padded input would yield zero output pixels, so reject it up front.
    assign in_knl  = EW'(i_cfg_knl);
    assign in_w2p  = EW'(i_cfg_in_w) + EW'(i_cfg_pad) + EW'(i_cfg_pad);
    assign in_h2p  = EW'(i_cfg_in_h) + EW'(i_cfg_pad) + EW'(i_cfg_pad);
    assign cfg_bad = (i_cfg_knl == '0) || (i_cfg_stride == '0) || (i_cfg_in_w == '0) ||
                     (i_cfg_in_h == '0) || (i_cfg_in_ch == '0) ||
                     (in_knl > in_h2p) || (in_knl > in_w2p);

    assign neg_pad_in  = '0 - CW'(i_cfg_pad);
    assign neg_pad_cfg = '0 - CW'(cfg_pad);

    assign wy_e     = EW'(wy);
    assign wx_e     = EW'(wx);
    assign ky_e     = EW'(ky);
    assign kx_e     = EW'(kx);
    assign knl_e    = EW'(cfg_knl);
    assign stride_e = EW'(cfg_stride);
    assign pad_e    = EW'(cfg_pad);
    assign w_e      = EW'(cfg_w);
    assign h_e      = EW'(cfg_h);
    assign iy_e     = wy_e + ky_e;
    assign ix_e     = wx_e + kx_e;

    // Look one stride ahead: the next window must still fit inside the padded frame.
    assign wy_more = (wy_e + stride_e + knl_e) <= (h_e + pad_e);
    assign wx_more = (wx_e + stride_e + knl_e) <= (w_e + pad_e);

    assign c_last    = (ch_cnt == cfg_ch - CH_WIDTH'(1));
    assign kx_last   = (kx == cfg_knl - KSIZE_WIDTH'(1));
    assign ky_last   = (ky == cfg_knl - KSIZE_WIDTH'(1));
    assign tap_last  = c_last && kx_last && ky_last;
    assign slot_last = tap_last && !wx_more && !wy_more;

    assign tap_pad = iy_e[EW-1] || ix_e[EW-1] || (iy_e >= h_e) || (ix_e >= w_e);
    assign tap_lin = tap_pad ? '0 : ADDR_WIDTH'(iy_e) * ADDR_WIDTH'(cfg_w) + ADDR_WIDTH'(ix_e);

    assign advance = (state == ST_RUN) && !i_stall && !slot_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (i_start) state_next = cfg_bad ? ST_DONE : ST_RUN;
            ST_RUN:   if (!i_stall && slot_last) state_next = ST_DRAIN;
            ST_DRAIN: if (!i_stall && !s1_valid) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        o_err  = 1'b0;
        o_rden = 1'b0;
        o_pad  = 1'b0;
        o_addr = out_addr;
        o_busy = (state != ST_IDLE);
        o_done = (state == ST_DONE);
        o_err  = (state == ST_DONE) && err_q;
        o_rden = out_valid && !out_pad && !i_stall;
        o_pad  = out_valid && out_pad && !i_stall;
    end

    // Config is captured only on an accepted start so mid-layer input changes have no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_base   <= '0;
            cfg_w      <= '0;
            cfg_h      <= '0;
            cfg_ch     <= '0;
            cfg_knl    <= '0;
            cfg_stride <= '0;
            cfg_pad    <= '0;
            err_q      <= 1'b0;
        end else if (start_ok) begin
            err_q <= cfg_bad;
            if (!cfg_bad) begin
                cfg_base   <= i_cfg_base_addr;
                cfg_w      <= i_cfg_in_w;
                cfg_h      <= i_cfg_in_h;
                cfg_ch     <= i_cfg_in_ch;
                cfg_knl    <= i_cfg_knl;
                cfg_stride <= i_cfg_stride;
                cfg_pad    <= i_cfg_pad;
            end
        end
    end

    // Nested odometer, channel innermost; the last slot leaves the counters parked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wy     <= '0;
            wx     <= '0;
            ky     <= '0;
            kx     <= '0;
            ch_cnt <= '0;
        end else if (start_ok) begin
            wy     <= neg_pad_in;
            wx     <= neg_pad_in;
            ky     <= '0;
            kx     <= '0;
            ch_cnt <= '0;
        end else if (advance) begin
            if (!c_last) begin
                ch_cnt <= ch_cnt + CH_WIDTH'(1);
            end else begin
                ch_cnt <= '0;
                if (!kx_last) begin
                    kx <= kx + KSIZE_WIDTH'(1);
                end else begin
                    kx <= '0;
                    if (!ky_last) begin
                        ky <= ky + KSIZE_WIDTH'(1);
                    end else begin
                        ky <= '0;
                        if (wx_more) begin
                            wx <= wx + CW'(cfg_stride);
                        end else begin
                            wx <= neg_pad_cfg;
                            wy <= wy + CW'(cfg_stride);
                        end
                    end
                end
            end
        end
    end

    data_req_addr_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CH_WIDTH   (CH_WIDTH)
    ) u_addr_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (!i_stall),
        .in_valid  (state == ST_RUN),
        .in_pad    (tap_pad),
        .in_lin    (tap_lin),
        .in_ch     (ch_cnt),
        .cfg_ch    (cfg_ch),
        .cfg_base  (cfg_base),
        .s1_valid  (s1_valid),
        .out_valid (out_valid),
        .out_pad   (out_pad),
        .out_addr  (out_addr)
    );

endmodule

// File: tb/tb_data_req_gen.sv
// Directed bench for data_req_gen: table of layer configs plus hand-written corner sequences.
module tb_data_req_gen;

    typedef struct packed {
        logic [31:0] base;
        logic [7:0]  w;
        logic [7:0]  h;
        logic [7:0]  ch;
        logic [2:0]  knl;
        logic [3:0]  stride;
        logic [3:0]  pad;
    } cfg_t;

    typedef struct packed {
        cfg_t        cfg;
        int          exp_slots;
        int          exp_reads;
        int          exp_pads;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        bit          exp_err;
    } vec_t;

    localparam logic [32:0] PADV = 33'h1_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stall = 1'b0;
    logic [31:0] i_cfg_base_addr = '0;
    logic [7:0]  i_cfg_in_w = '0;
    logic [7:0]  i_cfg_in_h = '0;
    logic [7:0]  i_cfg_in_ch = '0;
    logic [2:0]  i_cfg_knl = '0;
    logic [3:0]  i_cfg_stride = '0;
    logic [3:0]  i_cfg_pad = '0;
    logic [31:0] o_addr;
    logic        o_rden, o_pad, o_busy, o_done, o_err;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    int          first_cyc, done_cyc, n_reads, n_pads, stall_viol, both_viol;
    logic [31:0] first_addr, last_addr;
    bit          err_seen, timed_out;
    vec_t        vecs[9];

    always #5 clk = ~clk;

    data_req_gen dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_stall         (i_stall),
        .i_cfg_base_addr (i_cfg_base_addr),
        .i_cfg_in_w      (i_cfg_in_w),
        .i_cfg_in_h      (i_cfg_in_h),
        .i_cfg_in_ch     (i_cfg_in_ch),
        .i_cfg_knl       (i_cfg_knl),
        .i_cfg_stride    (i_cfg_stride),
        .i_cfg_pad       (i_cfg_pad),
        .o_addr          (o_addr),
        .o_rden          (o_rden),
        .o_pad           (o_pad),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_err           (o_err)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    function automatic vec_t mkVec(input logic [31:0] base, input int w, input int h, input int ch,
                                   input int k, input int s, input int p, input int slots,
                                   input int reads, input int pads, input logic [31:0] first,
                                   input logic [31:0] last, input bit err);
        vec_t v;
        v.cfg.base   = base;
        v.cfg.w      = 8'(w);
        v.cfg.h      = 8'(h);
        v.cfg.ch     = 8'(ch);
        v.cfg.knl    = 3'(k);
        v.cfg.stride = 4'(s);
        v.cfg.pad    = 4'(p);
        v.exp_slots  = slots;
        v.exp_reads  = reads;
        v.exp_pads   = pads;
        v.exp_first  = first;
        v.exp_last   = last;
        v.exp_err    = err;
        return v;
    endfunction

    // Reference schedule built from output-pixel indices rather than window-origin stepping.
    task automatic buildModel(input cfg_t c);
        int oh, ow, iy, ix;
        bit p;
        logic [31:0] a;
        exp_q.delete();
        oh = (int'(c.h) + 2 * int'(c.pad) - int'(c.knl)) / int'(c.stride) + 1;
        ow = (int'(c.w) + 2 * int'(c.pad) - int'(c.knl)) / int'(c.stride) + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < int'(c.knl); ky++)
                    for (int kx = 0; kx < int'(c.knl); kx++)
                        for (int cc = 0; cc < int'(c.ch); cc++) begin
                            iy = oy * int'(c.stride) - int'(c.pad) + ky;
                            ix = ox * int'(c.stride) - int'(c.pad) + kx;
                            p  = (iy < 0) || (ix < 0) || (iy >= int'(c.h)) || (ix >= int'(c.w));
                            a  = p ? 32'h0 : c.base + 32'((iy * int'(c.w) + ix) * int'(c.ch) + cc);
                            exp_q.push_back({p, a});
                        end
    endtask

    function automatic int firstDiff();
        int n;
        n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= got_q.size() || i >= exp_q.size()) return i;
            if (got_q[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    task automatic driveCfg(input cfg_t c);
        i_cfg_base_addr = c.base;
        i_cfg_in_w      = c.w;
        i_cfg_in_h      = c.h;
        i_cfg_in_ch     = c.ch;
        i_cfg_knl       = c.knl;
        i_cfg_stride    = c.stride;
        i_cfg_pad       = c.pad;
    endtask

    // Start a layer in cycle 0 and record every issued slot until o_done or the cycle budget runs out.
    task automatic applyStimulus(input cfg_t c, input int stall_pct, input int busy_start_cyc);
        got_q.delete();
        first_cyc  = -1;
        done_cyc   = -1;
        n_reads    = 0;
        n_pads     = 0;
        stall_viol = 0;
        both_viol  = 0;
        first_addr = '0;
        last_addr  = '0;
        err_seen   = 1'b0;
        timed_out  = 1'b1;
        @(posedge clk); #1;
        driveCfg(c);
        i_start = 1'b1;
        i_stall = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            @(posedge clk); #1;
            i_start = (k == busy_start_cyc);
            if (k == busy_start_cyc) begin
                i_cfg_knl       = 3'd0;
                i_cfg_base_addr = 32'hDEAD_0000;
            end
            i_stall = (int'($urandom_range(99)) < stall_pct);
            @(negedge clk);
            if (o_rden && i_stall) stall_viol++;
            if (o_rden && o_pad) both_viol++;
            if (o_rden || o_pad) begin
                if (first_cyc < 0) first_cyc = k;
                got_q.push_back({o_pad, o_pad ? 32'h0 : o_addr});
                if (o_rden) begin
                    if (n_reads == 0) first_addr = o_addr;
                    last_addr = o_addr;
                    n_reads++;
                end else begin
                    n_pads++;
                end
            end
            if (o_done) begin
                done_cyc  = k;
                err_seen  = o_err;
                timed_out = 1'b0;
                break;
            end
        end
        i_stall = 1'b0;
        i_start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [32:0] fw[9];
        logic [32:0] pw[9];
        logic [31:0] sw[4];
        int bad;

        vecs[0] = mkVec(32'h0,        4, 4, 1, 3, 1, 0,  36,  36,  0, 32'h0,        32'd15,   1'b0);
        vecs[1] = mkVec(32'h0,        4, 4, 1, 3, 1, 1, 144, 100, 44, 32'h0,        32'd15,   1'b0);
        vecs[2] = mkVec(32'h100,      3, 3, 3, 3, 1, 0,  27,  27,  0, 32'h100,      32'h11A,  1'b0);
        vecs[3] = mkVec(32'h0,        5, 5, 1, 3, 2, 0,  36,  36,  0, 32'h0,        32'd24,   1'b0);
        vecs[4] = mkVec(32'h10,       3, 3, 2, 2, 2, 1,  32,  18, 14, 32'h10,       32'h21,   1'b0);
        vecs[5] = mkVec(32'hFFFFFFFE, 1, 1, 4, 1, 1, 0,   4,   4,  0, 32'hFFFFFFFE, 32'h1,    1'b0);
        vecs[6] = mkVec(32'h0,        4, 4, 1, 0, 1, 0,   0,   0,  0, 32'h0,        32'h0,    1'b1);
        vecs[7] = mkVec(32'h0,        2, 4, 1, 3, 1, 0,   0,   0,  0, 32'h0,        32'h0,    1'b1);
        vecs[8] = mkVec(32'h0,        4, 4, 1, 3, 0, 0,   0,   0,  0, 32'h0,        32'h0,    1'b1);

        fw = '{33'd0, 33'd1, 33'd2, 33'd4, 33'd5, 33'd6, 33'd8, 33'd9, 33'd10};
        pw = '{PADV, PADV, PADV, PADV, 33'd0, 33'd1, PADV, 33'd4, 33'd5};
        sw = '{32'd0, 32'd2, 32'd10, 32'd12};

        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {o_addr, o_rden, o_pad, o_busy, o_done, o_err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_reset", {o_addr, o_rden, o_pad, o_busy, o_done, o_err}, 0);

        for (int i = 0; i < 9; i++) begin
            if (!vecs[i].exp_err) buildModel(vecs[i].cfg);
            applyStimulus(vecs[i].cfg, 0, 0);
            checkOutput($sformatf("v%0d.timeout", i), timed_out, 0);
            checkOutput($sformatf("v%0d.err", i), err_seen, vecs[i].exp_err);
            checkOutput($sformatf("v%0d.slots", i), got_q.size(), vecs[i].exp_slots);
            checkOutput($sformatf("v%0d.reads", i), n_reads, vecs[i].exp_reads);
            checkOutput($sformatf("v%0d.pads", i), n_pads, vecs[i].exp_pads);
            checkOutput($sformatf("v%0d.both", i), both_viol, 0);
            checkOutput($sformatf("v%0d.done_cyc", i), done_cyc,
                        vecs[i].exp_err ? 1 : 3 + vecs[i].exp_slots);
            if (!vecs[i].exp_err) begin
                checkOutput($sformatf("v%0d.first_cyc", i), first_cyc, 3);
                checkOutput($sformatf("v%0d.first_addr", i), first_addr, vecs[i].exp_first);
                checkOutput($sformatf("v%0d.last_addr", i), last_addr, vecs[i].exp_last);
                checkOutput($sformatf("v%0d.seq_diff_idx", i), firstDiff(), -1);
            end
        end

        applyStimulus(vecs[0].cfg, 0, 0);
        checkOutput("basic_len", got_q.size(), 36);
        for (int i = 0; i < 9 && i < got_q.size(); i++)
            checkOutput($sformatf("basic_win0[%0d]", i), got_q[i], fw[i]);

        applyStimulus(vecs[1].cfg, 0, 0);
        checkOutput("pad_len", got_q.size(), 144);
        for (int i = 0; i < 9 && i < got_q.size(); i++)
            checkOutput($sformatf("pad_win0[%0d]", i), got_q[i], pw[i]);

        applyStimulus(vecs[2].cfg, 0, 0);
        bad = 0;
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i] !== {1'b0, 32'h100 + 32'(i)}) bad++;
        checkOutput("chan_len", got_q.size(), 27);
        checkOutput("chan_order_bad", bad, 0);

        applyStimulus(vecs[3].cfg, 0, 0);
        for (int n = 0; n < 4 && 9 * n < got_q.size(); n++)
            checkOutput($sformatf("stride_win%0d_first", n), got_q[9 * n], {1'b0, sw[n]});

        buildModel(vecs[1].cfg);
        applyStimulus(vecs[1].cfg, 30, 0);
        checkOutput("stall_timeout", timed_out, 0);
        checkOutput("stall_seq_diff_idx", firstDiff(), -1);
        checkOutput("stall_rden_with_stall", stall_viol, 0);
        checkOutput("stall_both", both_viol, 0);

        applyStimulus(vecs[0].cfg, 0, 5);
        checkOutput("busy_start_err", err_seen, 0);
        checkOutput("busy_start_reads", n_reads, 36);
        checkOutput("busy_start_done_cyc", done_cyc, 39);
        checkOutput("busy_start_last_addr", last_addr, 15);

        // Abort a layer mid-run with async reset, then confirm a clean restart.
        @(posedge clk); #1;
        driveCfg(vecs[0].cfg);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_run", {o_addr, o_rden, o_pad, o_busy, o_done, o_err}, 0);
        @(negedge clk);
        checkOutput("rst_hold", {o_addr, o_rden, o_pad, o_busy, o_done, o_err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_released_idle", {o_addr, o_rden, o_pad, o_busy, o_done, o_err}, 0);
        buildModel(vecs[0].cfg);
        applyStimulus(vecs[0].cfg, 0, 0);
        checkOutput("restart_seq_diff_idx", firstDiff(), -1);
        checkOutput("restart_done_cyc", done_cyc, 39);
        checkOutput("restart_err", err_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
